// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter granting up to two writeback requesters per cycle onto two
// registered regfile write ports; flush blocks grants, refused cycles are counted.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_valid,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*PREG_W-1:0] req_pdst,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [1:0]              wr_valid,
  output logic [2*PREG_W-1:0]     wr_pdst,
  output logic [2*DATA_W-1:0]     wr_data,
  output logic [31:0]             stall_count
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [1:0]        r_wr_valid;
  logic [PREG_W-1:0] r_pdst0, r_pdst1;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic [31:0]       r_stall_count;

  logic [PREG_W-1:0] w_pdst [N_REQ];
  logic [DATA_W-1:0] w_data [N_REQ];
  logic              w_g0, w_g1;
  logic [PTR_W-1:0]  w_g0_idx, w_g1_idx, w_idx, w_last, w_ptr_nxt;
  logic [N_REQ-1:0]  w_ready;
  logic              w_refused;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_pdst[i] = req_pdst[i*PREG_W +: PREG_W];
      w_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Walk from the priority pointer; first valid takes port 0, second port 1.
  always_comb begin
    w_g0     = 1'b0;
    w_g1     = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
    w_idx    = '0;
    if (!rst && !flush_valid) begin
      for (int j = 0; j < N_REQ; j++) begin
        w_idx = PTR_W'((32'(r_rr_ptr) + 32'(j)) % N_REQ);
        if (req_valid[w_idx]) begin
          if (!w_g0) begin
            w_g0     = 1'b1;
            w_g0_idx = w_idx;
          end else if (!w_g1) begin
            w_g1     = 1'b1;
            w_g1_idx = w_idx;
          end
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_g0) w_ready[w_g0_idx] = 1'b1;
    if (w_g1) w_ready[w_g1_idx] = 1'b1;
  end

  assign w_refused = |(req_valid & ~w_ready);
  assign w_last    = w_g1 ? w_g1_idx : w_g0_idx;
  assign w_ptr_nxt = (w_last == LAST_IDX) ? '0 : w_last + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_wr_valid    <= '0;
      r_pdst0       <= '0;
      r_pdst1       <= '0;
      r_data0       <= '0;
      r_data1       <= '0;
      r_stall_count <= '0;
    end else begin
      r_wr_valid <= {w_g1, w_g0};
      if (w_g0) begin
        r_pdst0  <= w_pdst[w_g0_idx];
        r_data0  <= w_data[w_g0_idx];
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_g1) begin
        r_pdst1 <= w_pdst[w_g1_idx];
        r_data1 <= w_data[w_g1_idx];
      end
      // Flush cycles refuse everything but are not stalls.
      if (!flush_valid && w_refused && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign req_ready   = w_ready;
  assign wr_valid    = r_wr_valid;
  assign wr_pdst     = {r_pdst1, r_pdst0};
  assign wr_data     = {r_data1, r_data0};
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: queue-based round-robin reference model
// compared every cycle, plus directed literal checks of the corner cases.
module tb_regfile_wb_arbiter;
  localparam int N  = 4;
  localparam int PW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_valid = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [PW-1:0]   pd [N];
  logic [DW-1:0]   dt [N];
  logic [N*PW-1:0] req_pdst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [1:0]      wr_valid;
  logic [2*PW-1:0] wr_pdst;
  logic [2*DW-1:0] wr_data;
  logic [31:0]     stall_count;

  assign req_pdst = {pd[3], pd[2], pd[1], pd[0]};
  assign req_data = {dt[3], dt[2], dt[1], dt[0]};

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid),
    .req_valid(req_valid), .req_pdst(req_pdst), .req_data(req_data),
    .req_ready(req_ready), .wr_valid(wr_valid), .wr_pdst(wr_pdst),
    .wr_data(wr_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as seen after the most recent rising edge.
  int            m_ptr = 0;
  logic [31:0]   m_stall = '0;
  logic [1:0]    m_wv = '0;
  logic [PW-1:0] m_pd [2];
  logic [DW-1:0] m_dt [2];
  logic [1:0]    cand [$];
  logic [N-1:0]  m_er;
  logic [1:0]    m_ix;
  int            m_nv;
  bit            preload = 1'b0;

  // Compare process: inputs change on the falling edge, checked 3 time units later.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      m_ptr = 0; m_stall = '0; m_wv = '0;
      m_pd[0] = '0; m_pd[1] = '0; m_dt[0] = '0; m_dt[1] = '0;
    end
    if (preload) begin
      m_stall = 32'hFFFF_FFFE;
      preload = 1'b0;
    end
    chk("wr_valid",    64'(wr_valid), 64'(m_wv));
    chk("wr_pdst0",    64'(wr_pdst[PW-1:0]), 64'(m_pd[0]));
    chk("wr_pdst1",    64'(wr_pdst[2*PW-1:PW]), 64'(m_pd[1]));
    chk("wr_data0",    64'(wr_data[DW-1:0]), 64'(m_dt[0]));
    chk("wr_data1",    64'(wr_data[2*DW-1:DW]), 64'(m_dt[1]));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    chk("rr_ptr",      64'(dut.r_rr_ptr), 64'(m_ptr));

    // Valid requesters in rotated priority order; the first two win.
    cand = {};
    m_nv = 0;
    m_er = '0;
    for (int k = 0; k < N; k++) begin
      m_ix = 2'((m_ptr + k) % N);
      if (req_valid[m_ix]) begin
        m_nv++;
        if (!rst && !flush_valid) cand.push_back(m_ix);
      end
    end
    while (cand.size() > 2) void'(cand.pop_back());
    foreach (cand[i]) m_er[cand[i]] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(m_er));

    if (!rst) begin
      m_wv = 2'b00;
      if (cand.size() > 0) begin
        m_wv[0] = 1'b1;
        m_pd[0] = pd[cand[0]];
        m_dt[0] = dt[cand[0]];
        m_ptr   = (int'(cand[cand.size()-1]) + 1) % N;
      end
      if (cand.size() > 1) begin
        m_wv[1] = 1'b1;
        m_pd[1] = pd[cand[1]];
        m_dt[1] = dt[cand[1]];
      end
      if (!flush_valid && m_nv > cand.size() && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 32'd1;
    end
  end

  task automatic rand_slices();
    for (int i = 0; i < N; i++) begin
      pd[i] = PW'($urandom);
      dt[i] = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pd[i] = '0;
      dt[i] = '0;
    end
    repeat (3) @(negedge clk);

    // Full contention starting from pointer 0.
    @(negedge clk);
    rst = 1'b0;
    rand_slices();
    req_valid = 4'b1111;
    #4 chk("cont_ready_c0", 64'(req_ready), 64'h3);
    @(negedge clk);
    #4 chk("cont_ready_c1", 64'(req_ready), 64'hC);
    chk("cont_wpdst0_c1", 64'(wr_pdst[PW-1:0]), 64'(pd[0]));
    chk("cont_wpdst1_c1", 64'(wr_pdst[2*PW-1:PW]), 64'(pd[1]));
    chk("cont_stall_c1", 64'(stall_count), 64'd1);
    @(negedge clk);
    #4 chk("cont_ready_c2", 64'(req_ready), 64'h3);
    chk("cont_wpdst0_c2", 64'(wr_pdst[PW-1:0]), 64'(pd[2]));
    chk("cont_stall_c2", 64'(stall_count), 64'd2);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rand_slices();
      req_valid   = N'($urandom);
      flush_valid = ($urandom_range(0, 7) == 0);
    end

    // Reset in the middle of traffic with both ports live.
    @(negedge clk);
    flush_valid = 1'b0;
    req_valid   = 4'b1111;
    @(negedge clk);
    #1 chk("pre_rst_wr_valid", 64'(wr_valid), 64'h3);
    rst = 1'b1;
    #1 chk("rst_wr_valid", 64'(wr_valid), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_stall", 64'(stall_count), 64'h0);
    chk("rst_ptr", 64'(dut.r_rr_ptr), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0001;
    #4 chk("post_rst_ready", 64'(req_ready), 64'h1);

    // Single requester: req2 after the pointer moved to 1.
    @(negedge clk);
    req_valid = 4'b0100;
    pd[2] = 6'd17;
    dt[2] = 32'hDEAD_BEEF;
    #4 chk("single_ready", 64'(req_ready), 64'h4);

    // Wrap: pointer is 3, requesters 3 and 0.
    @(negedge clk);
    #1 chk("single_wr_valid", 64'(wr_valid), 64'h1);
    chk("single_wpdst0", 64'(wr_pdst[PW-1:0]), 64'd17);
    chk("single_wdata0", 64'(wr_data[DW-1:0]), 64'hDEAD_BEEF);
    chk("single_ptr", 64'(dut.r_rr_ptr), 64'd3);
    req_valid = 4'b1001;
    rand_slices();
    #3 chk("wrap_ready", 64'(req_ready), 64'h9);

    // Flush: grant in t-1, flush with all valid in t.
    @(negedge clk);
    #1 chk("wrap_ptr", 64'(dut.r_rr_ptr), 64'd1);
    chk("wrap_stall", 64'(stall_count), 64'd0);
    chk("wrap_wpdst0", 64'(wr_pdst[PW-1:0]), 64'(pd[3]));
    chk("wrap_wpdst1", 64'(wr_pdst[2*PW-1:PW]), 64'(pd[0]));
    rand_slices();
    req_valid = 4'b1111;
    @(negedge clk);
    flush_valid = 1'b1;
    #4 chk("flush_ready", 64'(req_ready), 64'h0);
    chk("flush_wr_valid_t", 64'(wr_valid), 64'h3);
    chk("flush_wpdst0_t", 64'(wr_pdst[PW-1:0]), 64'(pd[1]));
    chk("flush_wpdst1_t", 64'(wr_pdst[2*PW-1:PW]), 64'(pd[2]));
    chk("flush_ptr_t", 64'(dut.r_rr_ptr), 64'd3);
    chk("flush_stall_t", 64'(stall_count), 64'd1);
    @(negedge clk);
    flush_valid = 1'b0;
    req_valid = 4'b0000;
    #4 chk("flush_wr_valid_t1", 64'(wr_valid), 64'h0);
    chk("flush_ptr_t1", 64'(dut.r_rr_ptr), 64'd3);
    chk("flush_stall_t1", 64'(stall_count), 64'd1);

    // Saturation from one below the maximum.
    @(negedge clk);
    req_valid = 4'b1111;
    preload = 1'b1;
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1 release dut.r_stall_count;
    repeat (2) @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    #4 chk("sat_stall", 64'(stall_count), 64'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Round-robin arbiter that shares the physical register file write ports between the functional-unit writeback sources of the out-of-order core. It sits between the execution units and the issue-stage register file. Each cycle it grants up to two requesters, then presents the granted writes on registered write ports one cycle later. Flushes suppress new grants, and a saturating counter records cycles in which requests were refused.

## Interface
- N_REQ, 4, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- PREG_W, 6, physical register index width (64 pregs)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush_valid  input  1  pipeline flush this cycle; no grants issued
- req_valid  input  N_REQ  requester i has a pending write
- req_pdst  input  N_REQ*PREG_W  destination preg, slice i
- req_data  input  N_REQ*DATA_W  write data, slice i
- req_ready  output  N_REQ  grant to requester i (combinational)
- wr_valid  output  2  write port k enable (registered)
- wr_pdst  output  2*PREG_W  write port k preg (registered)
- wr_data  output  2*DATA_W  write port k data (registered)
- stall_count  output  32  saturating count of cycles with ≥1 refused valid request

## Operation
- State:
  - rr_ptr: clog2(N_REQ) bits, the highest-priority requester index.
  - Output registers for both ports.
  - stall_count.
- Scan order each cycle: rr_ptr, rr_ptr+1, … wrapping modulo N_REQ.
- Grant rules:
  - The first valid requester in scan order gets port 0. The second gets port 1. The rest are refused.
  - req_ready[i]=1 exactly for the granted indices.
  - A requester is never granted both ports.
- Flush:
  - flush_valid=1 forces req_ready=0 for all requesters.
  - Nothing is captured, rr_ptr is unchanged, and stall_count is unchanged. Flush cycles are not stalls.
- Pointer update:
  - If ≥1 grant: rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - If no grant: rr_ptr holds.
- Output capture:
  - wr_valid[k] <= port k granted.
  - wr_pdst[k]/wr_data[k] <= the granted slice, or hold their previous values when not granted.
- Same-pdst conflict: if both ports carry the same pdst in one cycle, port 1 is the younger scan position. The regfile resolves the conflict with port 1 priority. The arbiter does not check for it.
- Requester contract: req_valid, pdst and data are held stable until req_ready. Dropping req_valid without a grant is legal, and the request is then cancelled.
- stall_count:
  - Increments when no flush and (number of valid requests) > (number of grants).
  - Saturates at 2^32-1.

## Timing
- Reset values: rr_ptr=0, wr_valid=0, wr_pdst=0, wr_data=0, stall_count=0. req_ready=0 while rst is high.
- Grant latency: 0 cycles (same cycle as req_valid).
- Write latency: 1 cycle. The grant in cycle t produces wr_valid in cycle t+1.
- Throughput: 2 writes/cycle sustained.
- Fairness: a continuously valid requester is granted within ceil(N_REQ/2) cycles.
- Flush in cycle t:
  - A write granted in t-1 still appears in t, because it was already committed.
  - wr_valid=0 in t+1.
  - Grants resume in t+1.
- Reset mid-operation: all registered outputs clear immediately (asynchronous), including pending wr_valid. rr_ptr returns to 0.
- Wrap-around: when the last grant is at N_REQ-1, rr_ptr becomes 0.
- Single request: it takes port 0. Port 1 wr_valid=0 next cycle.
- Zero requests: no state change except wr_valid <= 0.

## Test plan
- Reset: assert rst mid-stream with wr_valid=2'b11. Required: outputs immediately 0, rr_ptr=0, stall_count=0. After release, req_valid=4'b0001 gives req_ready=4'b0001.
- Full contention: all 4 valid continuously from rr_ptr=0. Required:
  - Grants are 0011, 1100, 0011, … .
  - wr_pdst follows one cycle later.
  - stall_count increments by 1 per cycle.
- Wrap: rr_ptr=3, req_valid=4'b1001. Required:
  - Port0=req3, port1=req0, req_ready=4'b1001.
  - Next rr_ptr=1.
  - stall_count unchanged.
- Single requester: req_valid=4'b0100, pdst=6'd17, data=32'hDEADBEEF. Required:
  - Same cycle req_ready=4'b0100.
  - Next cycle wr_valid=2'b01, wr_pdst[0]=17, wr_data[0]=DEADBEEF.
  - Next rr_ptr=3.
- Flush: grant in t-1, then flush_valid in t with req_valid=4'b1111. Required:
  - req_ready=0 in t.
  - The t-1 write appears in t.
  - wr_valid=0 in t+1.
  - rr_ptr and stall_count unchanged in t.
- Saturation: preload stall_count to 32'hFFFFFFFE and apply 3 contended cycles. Required: the value holds at 32'hFFFFFFFF.
